pcie_tx_master_arb: RTL

//  Shares the single PCIe TX Avalon-MM write master between the two RDMAP masters: QueuePair (Qp*) and the

---
 rtl/pcie_tx_master_arb_pkg.sv | 30 +++
 rtl/pcie_tx_master_arb_stall_watchdog.sv | 44 ++++
 rtl/pcie_tx_master_arb.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_master_arb_pkg.sv
// Shared definitions for the PCIe TX master arbiter: grant codes, FSM states, owner encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcie_tx_master_arb_pkg;

    // Encoding of the grantOwner status output
    localparam logic [1:0] GRANT_IDLE = 2'd0;
    localparam logic [1:0] GRANT_QP   = 2'd1;
    localparam logic [1:0] GRANT_ARB  = 2'd2;

    // Encoding of the one-bit lastOwner register
    localparam logic OWNER_QP  = 1'b0;
    localparam logic OWNER_ARB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G_QP  = 2'd1,
        G_ARB = 2'd2
    } arbState_t;

    // Map an FSM state onto the externally visible grant code
    function automatic logic [1:0] grantCode(input arbState_t s);
        case (s)
            G_QP:    grantCode = GRANT_QP;
            G_ARB:   grantCode = GRANT_ARB;
            default: grantCode = GRANT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pcie_tx_master_arb_stall_watchdog.sv
// Counts consecutive stalled cycles on the merged master and raises a sticky error on a hang.
// Latency: timeoutErr rises the cycle after the TIMEOUT_CYC-th consecutive stalled cycle.
// Backpressure: observer only; never stalls or alters the datapath.
module stall_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    input  logic errClear,
    output logic timeoutErr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stallCnt;
    logic             trip;

    // The error trips on the stalled cycle that would take the count past TIMEOUT_CYC-1
    assign trip = stall && (stallCnt == CNT_W'(TIMEOUT_CYC - 1));

    // Consecutive-stall counter, saturating so a long hang cannot wrap it back to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (!stall) begin
            stallCnt <= '0;
        end else if (stallCnt != CNT_W'(TIMEOUT_CYC)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    // Sticky error flag; a trip in the same cycle as a clear keeps the flag set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeoutErr <= 1'b0;
        end else if (trip) begin
            timeoutErr <= 1'b1;
        end else if (errClear) begin
            timeoutErr <= 1'b0;
        end
    end

endmodule

// File: rtl/pcie_tx_master_arb.sv
// Round-robin share of the PCIe TX Avalon-MM write master between QueuePair and PCIeArbiter.
// Latency: grant registered one cycle after request; data path is a combinational mux once granted.
// Backpressure: owner sees PcieWaitRequest directly, non-owner held at WaitRequest=1; no handover while stalled.
module pcie_tx_master_arb
    import pcie_tx_master_arb_pkg::*;
#(
    parameter int MAX_BURST   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        QpChipSelect,
    input  logic        QpWrite,
    input  logic [63:0] QpAddress,
    input  logic [31:0] QpWriteData,
    input  logic [3:0]  QpByteEnable,
    output logic        QpWaitRequest,

    input  logic        ArbChipSelect,
    input  logic        ArbWrite,
    input  logic [63:0] ArbAddress,
    input  logic [31:0] ArbWriteData,
    input  logic [3:0]  ArbByteEnable,
    output logic        ArbWaitRequest,

    output logic        PcieChipSelect,
    output logic        PcieWrite,
    output logic [63:0] PcieAddress,
    output logic [31:0] PcieWriteData,
    output logic [3:0]  PcieByteEnable,
    input  logic        PcieWaitRequest,

    output logic [1:0]  grantOwner,
    output logic        timeoutErr,
    input  logic        errClear
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    arbState_t         state;
    arbState_t         stateNxt;
    logic              lastOwner;
    logic              lastOwnerNxt;
    logic [BEAT_W-1:0] beatCnt;
    logic [BEAT_W-1:0] beatCntNxt;

    logic      reqQp;
    logic      reqArb;
    logic      ownerReq;
    logic      otherReq;
    arbState_t otherState;
    logic      ownerLast;
    logic      accept;
    logic      leave;

    assign reqQp  = QpChipSelect & QpWrite;
    assign reqArb = ArbChipSelect & ArbWrite;

    // Resolve "owner" and "other" views of the current grant so both G_ states share one body
    always_comb begin
        ownerReq   = 1'b0;
        otherReq   = 1'b0;
        otherState = IDLE;
        ownerLast  = OWNER_QP;
        case (state)
            G_QP: begin
                ownerReq   = reqQp;
                otherReq   = reqArb;
                otherState = G_ARB;
                ownerLast  = OWNER_QP;
            end
            G_ARB: begin
                ownerReq   = reqArb;
                otherReq   = reqQp;
                otherState = G_QP;
                ownerLast  = OWNER_ARB;
            end
            default: ;
        endcase
    end

    // A stalled owner has ownerReq=1 and no accept, so neither leave condition fires mid-stall
    assign accept = ownerReq & ~PcieWaitRequest;
    assign leave  = (accept && (beatCnt == BEAT_W'(MAX_BURST - 1))) || !ownerReq;

    // Grant state, round-robin history and burst beat counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lastOwner <= OWNER_ARB;
            beatCnt   <= '0;
        end else begin
            state     <= stateNxt;
            lastOwner <= lastOwnerNxt;
            beatCnt   <= beatCntNxt;
        end
    end

    // Next grant: fair tie-break from IDLE, bounded burst and direct handover while granted
    always_comb begin
        stateNxt     = state;
        lastOwnerNxt = lastOwner;
        beatCntNxt   = beatCnt;
        case (state)
            IDLE: begin
                beatCntNxt = '0;
                if (reqQp && reqArb) begin
                    stateNxt = (lastOwner == OWNER_ARB) ? G_QP : G_ARB;
                end else if (reqQp) begin
                    stateNxt = G_QP;
                end else if (reqArb) begin
                    stateNxt = G_ARB;
                end
            end
            default: begin
                if (accept) begin
                    beatCntNxt = beatCnt + 1'b1;
                end
                if (leave) begin
                    lastOwnerNxt = ownerLast;
                    beatCntNxt   = '0;
                    if (otherReq) begin
                        stateNxt = otherState;
                    end else if (ownerReq) begin
                        stateNxt = state;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
        endcase
    end

    // Merged master mux and per-requester stall; everything quiet and stalled while idle
    always_comb begin
        PcieChipSelect = 1'b0;
        PcieWrite      = 1'b0;
        PcieAddress    = '0;
        PcieWriteData  = '0;
        PcieByteEnable = '0;
        QpWaitRequest  = 1'b1;
        ArbWaitRequest = 1'b1;
        case (state)
            G_QP: begin
                PcieChipSelect = QpChipSelect;
                PcieWrite      = QpWrite;
                PcieAddress    = QpAddress;
                PcieWriteData  = QpWriteData;
                PcieByteEnable = QpByteEnable;
                QpWaitRequest  = PcieWaitRequest;
            end
            G_ARB: begin
                PcieChipSelect = ArbChipSelect;
                PcieWrite      = ArbWrite;
                PcieAddress    = ArbAddress;
                PcieWriteData  = ArbWriteData;
                PcieByteEnable = ArbByteEnable;
                ArbWaitRequest = PcieWaitRequest;
            end
            default: ;
        endcase
    end

    assign grantOwner = grantCode(state);

    stall_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) uWatchdog (
        .clock      (clock),
        .reset      (reset),
        .stall      (PcieChipSelect & PcieWaitRequest),
        .errClear   (errClear),
        .timeoutErr (timeoutErr)
    );

endmodule
